// File: rtl/c5_ram_loader.sv
// c5_ram_loader: fills the on-chip BSRAM from a byte stream.
// Bytes are packed little-endian into 32-bit words. Each word is written at
// consecutive word addresses starting at BASE_ADR. Only the lanes that were
// received are enabled, so a final partial word leaves the other RAM lanes
// untouched.
// Optional feature macro: C5_LOADER_VERIFY_EN. When it is defined, every
// word is read back and compared on its written lanes, and O_err records any
// mismatch. When it is undefined, O_err is tied low.
module c5_ram_loader #(
  parameter logic [31:0] BASE_ADR = 32'h0000_0000,
  parameter int          LEN_W    = 16
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic             I_start,
  input  logic [LEN_W-1:0] I_len,
  input  logic             I_byte_stb,
  input  logic [7:0]       I_byte,
  output logic             O_byte_rdy,
  output logic             O_stb,
  output logic [3:0]       O_we,
  output logic [31:0]      O_adr,
  output logic [31:0]      O_dat,
  input  logic [31:0]      I_dat,
  output logic             O_busy,
  output logic             O_done,
  output logic             O_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
`ifdef C5_LOADER_VERIFY_EN
    S_VRD,
    S_VCMP,
`endif
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   rem_q;
  logic [31:0]        adr_q;
  logic [31:0]        word_q;
  logic [3:0]         mask_q;
  logic [1:0]         idx_q;
  logic               accept;
  logic               last_byte;
  logic               word_end;

`ifdef C5_LOADER_VERIFY_EN
  logic               err_q;
  logic [31:0]        lane_mask;
  logic               mismatch;

  assign lane_mask = {{8{mask_q[3]}}, {8{mask_q[2]}}, {8{mask_q[1]}}, {8{mask_q[0]}}};
  assign mismatch  = |((I_dat ^ word_q) & lane_mask);
  assign O_err     = err_q;
`else
  logic               unused_rdata;

  assign unused_rdata = ^I_dat;
  assign O_err        = 1'b0;
`endif

  assign accept    = (state_q == S_COLLECT) && I_byte_stb;
  assign last_byte = accept && ((idx_q == 2'd3) || (rem_q == LEN_W'(1)));
  assign O_adr     = adr_q;
  assign O_dat     = word_q;

  // State register; reset drops any partial word and returns to IDLE.
  always_ff @(posedge I_clk) begin
    if (I_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state selection and the output decode of the current state.
  always_comb begin
    state_d    = state_q;
    word_end   = 1'b0;
    O_byte_rdy = 1'b0;
    O_stb      = 1'b0;
    O_we       = 4'h0;
    O_busy     = 1'b1;
    O_done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        O_busy = 1'b0;
        if (I_start) state_d = (I_len == '0) ? S_DONE : S_COLLECT;
      end
      S_COLLECT: begin
        O_byte_rdy = 1'b1;
        if (last_byte) state_d = S_WRITE;
      end
      S_WRITE: begin
        O_stb = 1'b1;
        O_we  = mask_q;
`ifdef C5_LOADER_VERIFY_EN
        state_d = S_VRD;
`else
        word_end = 1'b1;
        state_d  = (rem_q == '0) ? S_DONE : S_COLLECT;
`endif
      end
`ifdef C5_LOADER_VERIFY_EN
      S_VRD: begin
        O_stb   = 1'b1;
        state_d = S_VCMP;
      end
      S_VCMP: begin
        word_end = 1'b1;
        state_d  = (rem_q == '0) ? S_DONE : S_COLLECT;
      end
`endif
      S_DONE: begin
        O_busy  = 1'b0;
        O_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        O_busy  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath: capture the job, pack bytes into lanes, step to the next word.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      rem_q  <= '0;
      adr_q  <= '0;
      word_q <= '0;
      mask_q <= '0;
      idx_q  <= '0;
`ifdef C5_LOADER_VERIFY_EN
      err_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (I_start) begin
            rem_q  <= I_len;
            adr_q  <= BASE_ADR;
            word_q <= '0;
            mask_q <= '0;
            idx_q  <= '0;
`ifdef C5_LOADER_VERIFY_EN
            err_q  <= 1'b0;
`endif
          end
        end
        S_COLLECT: begin
          if (accept) begin
            word_q[{idx_q, 3'b000} +: 8] <= I_byte;
            mask_q[idx_q]                <= 1'b1;
            idx_q                        <= idx_q + 2'd1;
            rem_q                        <= rem_q - LEN_W'(1);
          end
        end
`ifdef C5_LOADER_VERIFY_EN
        S_VCMP: begin
          if (mismatch) err_q <= 1'b1;
        end
`endif
        default: ;
      endcase
      if (word_end && (rem_q != '0)) begin
        adr_q  <= adr_q + 32'd4;
        word_q <= '0;
        mask_q <= '0;
        idx_q  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_c5_ram_loader.sv
// tb_c5_ram_loader: randomized, self-checking bench for c5_ram_loader.
// It keeps a word-level model of the expected RAM writes, built from the byte
// list. A small model RAM answers the read-back accesses, and its lane 2 can
// be forced to read as zero. The bench follows C5_LOADER_VERIFY_EN when that
// macro is defined.
`timescale 1ns/1ps
module tb_c5_ram_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
`ifdef C5_LOADER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic        I_clk = 1'b0;
  logic        I_rst;
  logic        I_start;
  logic [15:0] I_len;
  logic        I_byte_stb;
  logic [7:0]  I_byte;
  logic [31:0] I_dat = '0;
  logic        O_byte_rdy, O_stb, O_busy, O_done, O_err;
  logic [3:0]  O_we;
  logic [31:0] O_adr, O_dat;

  typedef struct {
    logic [31:0] adr;
    logic [3:0]  we;
    logic [31:0] dat;
  } wr_t;

  int          total = 0;
  int          bad   = 0;
  wr_t         exp_q[$];
  wr_t         wr_log[$];
  logic [31:0] rd_q[$];
  logic [7:0]  src[$];
  logic [31:0] mem [0:63];
  bit          stuck_lane2 = 1'b0;
  bit          chk_en = 1'b0;
  bit          err_exp;
  int          last_done_cyc;
  logic        last_err;

  c5_ram_loader #(.BASE_ADR(BASE), .LEN_W(16)) dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_start(I_start), .I_len(I_len),
    .I_byte_stb(I_byte_stb), .I_byte(I_byte), .O_byte_rdy(O_byte_rdy),
    .O_stb(O_stb), .O_we(O_we), .O_adr(O_adr), .O_dat(O_dat), .I_dat(I_dat),
    .O_busy(O_busy), .O_done(O_done), .O_err(O_err)
  );

  always #5 I_clk = ~I_clk;

  function automatic logic [31:0] laneMask(input logic [3:0] we);
    logic [31:0] m;
    for (int l = 0; l < 4; l++) m[8*l +: 8] = {8{we[l]}};
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Model RAM with one cycle of read latency; lane 2 can be forced to read as zero.
  always @(posedge I_clk) begin
    if (O_stb && (O_we != 4'h0)) begin
      for (int l = 0; l < 4; l++)
        if (O_we[l]) mem[O_adr[7:2]][8*l +: 8] <= O_dat[8*l +: 8];
    end
    if (O_stb && (O_we == 4'h0))
      I_dat <= mem[O_adr[7:2]] & (stuck_lane2 ? 32'hFF00_FFFF : 32'hFFFF_FFFF);
  end

  // Compare process: every bus access is checked against the expected-write model.
  always @(negedge I_clk) begin
    wr_t e;
    if (chk_en && !I_rst) begin
      if (O_stb && (O_we != 4'h0)) begin
        e.adr = O_adr; e.we = O_we; e.dat = O_dat;
        wr_log.push_back(e);
        if (exp_q.size() == 0) checkOutput("unexpected_write", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          checkOutput("wr_adr", O_adr, e.adr);
          checkOutput("wr_we", 32'(O_we), 32'(e.we));
          checkOutput("wr_dat", O_dat & laneMask(e.we), e.dat & laneMask(e.we));
          if (VERIFY) rd_q.push_back(e.adr);
        end
      end
      if (O_stb && (O_we == 4'h0)) begin
        if (rd_q.size() == 0) checkOutput("unexpected_read", 32'd1, 32'd0);
        else checkOutput("rd_adr", O_adr, rd_q.pop_front());
      end
      checkOutput("rdy_during_stb", 32'(O_stb & O_byte_rdy), 32'd0);
      checkOutput("busy_with_done", 32'(O_busy & O_done), 32'd0);
    end
  end

  // Word-level model: lane l of word k carries byte 4k+l; missing bytes leave the lane disabled.
  task automatic buildModel(input int len);
    int nw;
    wr_t w;
    exp_q.delete();
    rd_q.delete();
    err_exp = 1'b0;
    nw = (len + 3) / 4;
    for (int k = 0; k < nw; k++) begin
      w.adr = BASE + 32'(4 * k);
      w.we  = 4'h0;
      w.dat = '0;
      for (int l = 0; l < 4; l++) begin
        if (4 * k + l < len) begin
          w.we[l] = 1'b1;
          w.dat[8*l +: 8] = src[4*k+l];
          if (VERIFY && stuck_lane2 && (l == 2) && (src[4*k+l] != 8'h00)) err_exp = 1'b1;
        end
      end
      exp_q.push_back(w);
    end
  endtask

  // Run one load. stall_pct is the chance of idling the source in a cycle.
  // busy_start_at >= 0 pulses a stray start in that cycle.
  // rst_after >= 0 resets the DUT once that many bytes have been accepted.
  task automatic applyStimulus(input int len, input int stall_pct, input int busy_start_at, input int rst_after);
    int  nw, exp_off, cyc, sent;
    bit  acc, stop;
    nw      = (len + 3) / 4;
    exp_off = len + nw * (VERIFY ? 3 : 1) + 1;
    buildModel(len);
    wr_log.delete();
    @(negedge I_clk);
    I_start = 1'b1;
    I_len   = 16'(len);
    cyc = 0; sent = 0; stop = 1'b0;
    I_byte_stb = (len > 0);
    I_byte     = (len > 0) ? src[0] : 8'h00;
    acc = I_byte_stb && O_byte_rdy;
    while (!stop) begin
      @(negedge I_clk);
      cyc++;
      if (acc) sent++;
      I_start = (cyc == busy_start_at);
      if (cyc == busy_start_at) I_len = 16'd1;
      if (cyc == 1) begin
        checkOutput("busy_after_start", 32'(O_busy), 32'(len != 0));
        checkOutput("err_cleared_on_start", 32'(O_err), 32'd0);
      end
      if (O_done) begin
        stop = 1'b1;
        last_done_cyc = cyc;
        last_err = O_err;
        if (stall_pct == 0) checkOutput("done_cycle", 32'(cyc), 32'(exp_off));
        checkOutput("err_at_done", 32'(O_err), 32'(err_exp));
        checkOutput("bytes_taken", 32'(sent), 32'(len));
        I_byte_stb = 1'b0;
        @(negedge I_clk);
        checkOutput("done_one_cycle", 32'(O_done), 32'd0);
        checkOutput("busy_after_done", 32'(O_busy), 32'd0);
        checkOutput("writes_left", 32'(exp_q.size()), 32'd0);
        checkOutput("reads_left", 32'(rd_q.size()), 32'd0);
      end else if ((rst_after >= 0) && (sent == rst_after)) begin
        stop = 1'b1;
        I_rst = 1'b1;
        I_byte_stb = 1'b0;
        exp_q.delete();
        rd_q.delete();
        @(negedge I_clk);
        I_rst = 1'b0;
        checkOutput("rst_byte_rdy", 32'(O_byte_rdy), 32'd0);
        checkOutput("rst_stb", 32'(O_stb), 32'd0);
        checkOutput("rst_we", 32'(O_we), 32'd0);
        checkOutput("rst_adr", O_adr, 32'd0);
        checkOutput("rst_dat", O_dat, 32'd0);
        checkOutput("rst_busy", 32'(O_busy), 32'd0);
        checkOutput("rst_done", 32'(O_done), 32'd0);
        checkOutput("rst_err", 32'(O_err), 32'd0);
        repeat (8) begin
          @(negedge I_clk);
          checkOutput("no_done_after_rst", 32'(O_done), 32'd0);
        end
      end else if (cyc > 400) begin
        stop = 1'b1;
        checkOutput("done_timeout", 32'd0, 32'd1);
      end else begin
        if ((sent < len) && ($urandom_range(99) >= 32'(stall_pct))) begin
          I_byte_stb = 1'b1;
          I_byte     = src[sent];
        end else begin
          I_byte_stb = 1'b0;
          I_byte     = 8'($urandom);
        end
        acc = I_byte_stb && O_byte_rdy;
      end
    end
    I_start    = 1'b0;
    I_byte_stb = 1'b0;
  endtask

  task automatic randomBytes(input int len);
    src.delete();
    for (int i = 0; i < len; i++) src.push_back(8'($urandom));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    I_rst = 1'b1; I_start = 1'b0; I_len = '0; I_byte_stb = 1'b0; I_byte = '0;
    repeat (3) @(negedge I_clk);
    I_rst = 1'b0;
    @(negedge I_clk);
    checkOutput("reset_outputs", {O_adr[15:0], O_dat[7:0], O_we, O_byte_rdy, O_stb, O_busy, O_done}, 32'd0);
    checkOutput("reset_dat", O_dat, 32'd0);
    checkOutput("reset_err", 32'(O_err), 32'd0);
    chk_en = 1'b1;

    $display("[TB] six-byte stream with a partial final word");
    src.delete();
    src.push_back(8'h11); src.push_back(8'h22); src.push_back(8'h33);
    src.push_back(8'h44); src.push_back(8'h55); src.push_back(8'h66);
    applyStimulus(6, 0, -1, -1);
    checkOutput("lit_nwrites", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) begin
      checkOutput("lit_w0_adr", wr_log[0].adr, 32'h0000_0000);
      checkOutput("lit_w0_we", 32'(wr_log[0].we), 32'h0000_000F);
      checkOutput("lit_w0_dat", wr_log[0].dat, 32'h4433_2211);
      checkOutput("lit_w1_adr", wr_log[1].adr, 32'h0000_0004);
      checkOutput("lit_w1_we", 32'(wr_log[1].we), 32'h0000_0003);
      checkOutput("lit_w1_dat", 32'(wr_log[1].dat[15:0]), 32'h0000_6655);
    end
    checkOutput("lit_done_cycle", 32'(last_done_cyc), VERIFY ? 32'd13 : 32'd9);

    $display("[TB] zero length");
    src.delete();
    applyStimulus(0, 0, -1, -1);
    checkOutput("zero_len_done_cycle", 32'(last_done_cyc), 32'd1);
    checkOutput("zero_len_no_write", 32'(wr_log.size()), 32'd0);

    $display("[TB] source stalls, eight bytes");
    randomBytes(8);
    applyStimulus(8, 50, -1, -1);
    checkOutput("stall_nwrites", 32'(wr_log.size()), 32'd2);

    $display("[TB] reset mid-load, then a fresh load");
    randomBytes(4);
    applyStimulus(4, 0, -1, 2);
    randomBytes(4);
    applyStimulus(4, 0, -1, -1);
    if (wr_log.size() > 0) checkOutput("fresh_adr", wr_log[0].adr, BASE);
    else checkOutput("fresh_write_seen", 32'd0, 32'd1);

    $display("[TB] read-back against RAM with lane 2 stuck at zero");
    src.delete();
    src.push_back(8'hAA); src.push_back(8'hBB); src.push_back(8'hCC); src.push_back(8'hDD);
    stuck_lane2 = 1'b1;
    applyStimulus(4, 0, -1, -1);
    checkOutput("lit_stuck_dat", (wr_log.size() > 0) ? wr_log[0].dat : 32'hFFFF_FFFF, 32'hDDCC_BBAA);
    checkOutput("lit_stuck_err", 32'(last_err), VERIFY ? 32'd1 : 32'd0);
    stuck_lane2 = 1'b0;
    src.delete();
    applyStimulus(0, 0, -1, -1);
    checkOutput("err_cleared_after", 32'(O_err), 32'd0);

    $display("[TB] start pulsed while busy");
    randomBytes(8);
    applyStimulus(8, 0, 2, -1);

    $display("[TB] random lengths with random stalls");
    for (int t = 0; t < 8; t++) begin
      int len;
      len = int'($urandom_range(1, 13));
      randomBytes(len);
      stuck_lane2 = (t % 3 == 0);
      applyStimulus(len, 40, -1, -1);
    end
    stuck_lane2 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
